// File: rtl/branch_predictor_if.sv
// Fetch/execute-side bundle for the branch predictor: prediction request/response,
// resolved-branch feedback, table flush and the mispredict statistics.
interface branch_predictor_if;
  logic        pred_req_valid;
  logic [31:0] pred_req_pc;
  logic        pred_req_ready;
  logic        pred_resp_valid;
  logic        pred_resp_taken;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_taken;
  logic        res_pred_taken;
  logic        mispredict;
  logic        flush;
  logic [15:0] mispredict_count;

  modport master (
    output pred_req_valid, pred_req_pc, res_valid, res_pc, res_taken, res_pred_taken, flush,
    input  pred_req_ready, pred_resp_valid, pred_resp_taken, mispredict, mispredict_count
  );

  modport slave (
    input  pred_req_valid, pred_req_pc, res_valid, res_pc, res_taken, res_pred_taken, flush,
    output pred_req_ready, pred_resp_valid, pred_resp_taken, mispredict, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal predictor, 2-bit counters indexed by pc[INDEX_BITS+1:2]; response one cycle after accept.
// Requests are refused (ready low) for the 2^INDEX_BITS cycles of a flush sweep.
module branch_predictor #(
  parameter int INDEX_BITS = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [INDEX_BITS-1:0] PTR_LAST = '1;
  localparam logic [INDEX_BITS-1:0] PTR_ONE  = INDEX_BITS'(1);

  typedef enum logic {RUN, CLEAR} state_t;

  state_t                  state_q, state_d;
  logic [INDEX_BITS-1:0]   clr_ptr_q, clr_ptr_d;
  // Counters packed two bits per entry so the whole table resets in one assignment.
  logic [2*ENTRIES-1:0]    tbl_q;
  logic                    resp_vld_q, resp_taken_q;
  logic                    mispredict_q;
  logic [15:0]             mis_cnt_q;

  logic [INDEX_BITS-1:0]   req_idx, res_idx;
  logic [1:0]              req_cnt, res_cnt, res_cnt_d;
  logic                    req_accept, mis_evt;
  logic                    unused_pc_bits;

  assign req_idx = bp.pred_req_pc[INDEX_BITS+1:2];
  assign res_idx = bp.res_pc[INDEX_BITS+1:2];
  assign unused_pc_bits = ^{bp.pred_req_pc[31:INDEX_BITS+2], bp.pred_req_pc[1:0],
                            bp.res_pc[31:INDEX_BITS+2], bp.res_pc[1:0]};

  assign req_cnt    = tbl_q[{req_idx, 1'b0} +: 2];
  assign res_cnt    = tbl_q[{res_idx, 1'b0} +: 2];
  assign req_accept = bp.pred_req_valid && (state_q == RUN);
  assign mis_evt    = bp.res_valid && (bp.res_taken != bp.res_pred_taken);

  always_comb begin
    res_cnt_d = res_cnt;
    if (bp.res_taken) begin
      if (res_cnt != 2'b11) res_cnt_d = res_cnt + 2'd1;
    end else begin
      if (res_cnt != 2'b00) res_cnt_d = res_cnt - 2'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == RUN) begin
      if (bp.flush) begin
        state_d   = CLEAR;
        clr_ptr_d = '0;
      end
    end else begin
      if (bp.flush) begin
        clr_ptr_d = '0;
      end else if (clr_ptr_q == PTR_LAST) begin
        state_d   = RUN;
        clr_ptr_d = '0;
      end else begin
        clr_ptr_d = clr_ptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // The sweep owns the table write port; resolved-branch training is dropped meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_q <= {ENTRIES{2'b01}};
    end else if (state_q == CLEAR) begin
      tbl_q[{clr_ptr_q, 1'b0} +: 2] <= 2'b01;
    end else if (bp.res_valid) begin
      tbl_q[{res_idx, 1'b0} +: 2] <= res_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_vld_q   <= 1'b0;
      resp_taken_q <= 1'b0;
      mispredict_q <= 1'b0;
      mis_cnt_q    <= 16'h0000;
    end else begin
      resp_vld_q   <= req_accept;
      resp_taken_q <= req_accept && req_cnt[1];
      mispredict_q <= mis_evt;
      if (mis_evt && (mis_cnt_q != 16'hFFFF)) mis_cnt_q <= mis_cnt_q + 16'd1;
    end
  end

  assign bp.pred_req_ready   = (state_q == RUN);
  assign bp.pred_resp_valid  = resp_vld_q;
  assign bp.pred_resp_taken  = resp_taken_q;
  assign bp.mispredict       = mispredict_q;
  assign bp.mispredict_count = mis_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus random stimulus against a table-of-integers reference model of the predictor.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_predictor_if bus ();
  branch_predictor #(.INDEX_BITS(6)) dut (.clk(clk), .rst_n(rst_n), .bp(bus));

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference state: one integer counter 0..3 per entry, remaining busy cycles, event count.
  int tbl [64];
  int busy;
  int cnt;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (tbl[i]) tbl[i] = 1;
    busy = 0;
    cnt  = 0;
  endtask

  task automatic idle_inputs();
    bus.pred_req_valid = 1'b0;
    bus.pred_req_pc    = 32'h0;
    bus.res_valid      = 1'b0;
    bus.res_pc         = 32'h0;
    bus.res_taken      = 1'b0;
    bus.res_pred_taken = 1'b0;
    bus.flush          = 1'b0;
  endtask

  // Advance one clock edge with the currently driven inputs, predicting outputs first.
  task automatic tick(input bit chk_en);
    bit acc, e_vld, e_tk, e_mis;
    int ri;
    acc   = bus.pred_req_valid && (busy == 0);
    e_vld = acc;
    e_tk  = acc && (tbl[idx_of(bus.pred_req_pc)] >= 2);
    e_mis = bus.res_valid && (bus.res_taken != bus.res_pred_taken);
    if (e_mis && cnt < 65535) cnt++;
    if (bus.res_valid && busy == 0) begin
      ri = idx_of(bus.res_pc);
      if (bus.res_taken) tbl[ri] = (tbl[ri] == 3) ? 3 : tbl[ri] + 1;
      else               tbl[ri] = (tbl[ri] == 0) ? 0 : tbl[ri] - 1;
    end
    if (bus.flush) begin
      busy = 64;
      foreach (tbl[i]) tbl[i] = 1;
    end else if (busy > 0) begin
      busy--;
    end
    @(posedge clk);
    #1;
    if (chk_en) begin
      chk("resp_valid", bus.pred_resp_valid, e_vld);
      chk("resp_taken", bus.pred_resp_taken, e_tk);
      chk("mispredict", bus.mispredict, e_mis);
      chk("mis_count", bus.mispredict_count, cnt);
      chk("req_ready", bus.pred_req_ready, busy == 0);
    end
  endtask

  task automatic req(input logic [31:0] pc);
    bus.pred_req_valid = 1'b1;
    bus.pred_req_pc    = pc;
    tick(1);
    bus.pred_req_valid = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input bit taken, input bit pred);
    bus.res_valid      = 1'b1;
    bus.res_pc         = pc;
    bus.res_taken      = taken;
    bus.res_pred_taken = pred;
    tick(1);
    bus.res_valid = 1'b0;
  endtask

  task automatic scan_all_nt(input string tag);
    for (int i = 0; i < 64; i++) begin
      req(32'(i * 4) + 32'h0000_4000);
      chk(tag, bus.pred_resp_taken, 1'b0);
    end
  endtask

  initial begin
    int n;
    bit tk;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", bus.pred_resp_valid, 1'b0);
    chk("rst_resp_taken", bus.pred_resp_taken, 1'b0);
    chk("rst_mispredict", bus.mispredict, 1'b0);
    chk("rst_count", bus.mispredict_count, 16'h0000);
    chk("rst_ready", bus.pred_req_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh entry is weak-NT; the response lasts a single cycle.
    req(32'h100);
    chk("first_resp_valid", bus.pred_resp_valid, 1'b1);
    chk("first_resp_taken", bus.pred_resp_taken, 1'b0);
    tick(1);
    chk("resp_pulse_end", bus.pred_resp_valid, 1'b0);

    // Training upward, saturation at strong-T, then downward to strong-NT.
    repeat (3) upd(32'h100, 1'b1, 1'b1);
    req(32'h100);
    chk("trained_taken", bus.pred_resp_taken, 1'b1);
    repeat (2) upd(32'h100, 1'b1, 1'b1);
    upd(32'h100, 1'b0, 1'b0);
    req(32'h100);
    chk("sat_high_taken", bus.pred_resp_taken, 1'b1);
    repeat (3) upd(32'h100, 1'b0, 1'b0);
    req(32'h100);
    chk("trained_nt", bus.pred_resp_taken, 1'b0);
    upd(32'h100, 1'b0, 1'b0);
    repeat (2) upd(32'hABCD_0103, 1'b1, 1'b1);
    req(32'h100);
    chk("alias_pc_bits", bus.pred_resp_taken, 1'b1);

    // Same-edge request and update return the pre-update value.
    bus.pred_req_valid = 1'b1;
    bus.pred_req_pc    = 32'h104;
    upd(32'h104, 1'b1, 1'b1);
    bus.pred_req_valid = 1'b0;
    chk("same_edge_taken", bus.pred_resp_taken, 1'b0);
    req(32'h104);
    chk("after_same_edge", bus.pred_resp_taken, 1'b1);

    upd(32'h200, 1'b1, 1'b0);
    chk("mis_pulse", bus.mispredict, 1'b1);
    chk("mis_count_one", bus.mispredict_count, 16'h0001);
    tick(1);
    chk("mis_pulse_end", bus.mispredict, 1'b0);

    // Drive the counter into saturation with back-to-back mispredicts.
    bus.res_valid = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      tk = 1'($urandom_range(0, 1));
      bus.res_pc         = $urandom;
      bus.res_taken      = tk;
      bus.res_pred_taken = !tk;
      tick(0);
    end
    tick(1);
    chk("count_saturated", bus.mispredict_count, 16'hFFFF);
    bus.res_valid = 1'b0;
    tick(1);

    // Random mix of requests, updates and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      bus.pred_req_valid = 1'($urandom_range(0, 1));
      bus.pred_req_pc    = $urandom;
      bus.res_valid      = 1'($urandom_range(0, 1));
      bus.res_pc         = $urandom_range(0, 255);
      bus.res_taken      = 1'($urandom_range(0, 1));
      bus.res_pred_taken = 1'($urandom_range(0, 1));
      bus.flush          = ($urandom_range(0, 99) == 0);
      tick(1);
    end
    idle_inputs();
    n = 0;
    while (busy > 0 && n < 100) begin
      tick(1);
      n++;
    end

    // Flush sweep length, ignored updates, and table contents afterwards.
    for (int i = 0; i < 8; i++) repeat (3) upd(32'(i * 4), 1'b1, 1'b1);
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    chk("flush_ready_low", bus.pred_req_ready, 1'b0);
    n = 0;
    while (bus.pred_req_ready !== 1'b1 && n < 200) begin
      bus.pred_req_valid = 1'b1;
      bus.pred_req_pc    = $urandom_range(0, 255);
      bus.res_valid      = 1'b1;
      bus.res_pc         = $urandom_range(0, 31);
      bus.res_taken      = 1'b1;
      bus.res_pred_taken = 1'b1;
      tick(1);
      n++;
    end
    idle_inputs();
    chk("clear_len", n, 64);
    scan_all_nt("post_flush_nt");

    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    repeat (29) tick(1);
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    n = 0;
    while (bus.pred_req_ready !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    chk("reflush_len", n, 64);

    // Asynchronous reset in the middle of a sweep.
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    repeat (20) tick(1);
    upd(32'h40, 1'b0, 1'b1);
    chk("mis_in_clear", bus.mispredict, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_resp_valid", bus.pred_resp_valid, 1'b0);
    chk("arst_mispredict", bus.mispredict, 1'b0);
    chk("arst_count", bus.mispredict_count, 16'h0000);
    chk("arst_ready", bus.pred_req_ready, 1'b1);
    model_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    scan_all_nt("post_arst_nt");
    upd(32'h10, 1'b1, 1'b1);
    req(32'h10);
    chk("post_arst_train", bus.pred_resp_taken, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 6, giving log2 of the pattern table entry count (64 entries at default).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port pred_req_valid  input  1  fetch presents a PC for prediction.
REQ-005 SHALL have port pred_req_pc  input  32  PC of the fetched branch.
REQ-006 SHALL have port pred_req_ready  output  1  predictor accepts requests this cycle.
REQ-007 SHALL have port pred_resp_valid  output  1  prediction result valid, one-cycle pulse.
REQ-008 SHALL have port pred_resp_taken  output  1  predicted direction, 1 = taken.
REQ-009 SHALL have port res_valid  input  1  execute stage reports a resolved conditional branch.
REQ-010 SHALL have port res_pc  input  32  PC of the resolved branch.
REQ-011 SHALL have port res_taken  input  1  actual outcome from the branch comparator.
REQ-012 SHALL have port res_pred_taken  input  1  direction that was predicted for that branch.
REQ-013 SHALL have port mispredict  output  1  registered pulse: the resolved branch was mispredicted.
REQ-014 SHALL have port flush  input  1  request to clear the whole table.
REQ-015 SHALL have port mispredict_count  output  16  saturating mispredict counter.

Function
REQ-016 SHALL index the table with pc[INDEX_BITS+1:2]; pc[1:0] and upper bits SHALL be ignored.
REQ-017 SHALL hold one 2-bit saturating counter per entry: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; predict taken = counter bit 1.
REQ-018 SHALL accept a request at a rising edge where pred_req_valid && pred_req_ready; pred_resp_valid SHALL be 1 for exactly the following cycle, with pred_resp_taken from the accepted entry; both SHALL be 0 otherwise.
REQ-019 SHALL, at an edge with res_valid, increment the res_pc entry when res_taken=1 (saturating at 11) and decrement it when res_taken=0 (saturating at 00).
REQ-020 SHALL, when a request and an update hit the same index at the same edge, return the pre-update counter value to the request.
REQ-021 SHALL drive mispredict=1 for one cycle after an edge with res_valid && (res_taken != res_pred_taken), else 0.
REQ-022 SHALL increment mispredict_count by 1 on each mispredict event, holding at 16'hFFFF.
REQ-023 SHALL implement FSM states RUN and CLEAR; pred_req_ready = (state == RUN).
REQ-024 SHALL move RUN->CLEAR at an edge with flush=1, loading the clear pointer with 0; a request accepted at that same edge SHALL be served from the old table.
REQ-025 SHALL, in CLEAR, write 01 into the entry at the clear pointer and increment the pointer every cycle; after writing entry 2^INDEX_BITS-1 SHALL return to RUN (CLEAR lasts exactly 2^INDEX_BITS cycles).
REQ-026 SHALL, on flush=1 while in CLEAR, restart the pointer at 0 and remain in CLEAR.
REQ-027 SHALL ignore res_valid table updates while in CLEAR; mispredict and mispredict_count SHALL still operate.

Reset
REQ-028 SHALL, on rst_n=0 and independent of clk, set every table entry to 01, state to RUN, clear pointer to 0, pred_resp_valid, pred_resp_taken, mispredict to 0, and mispredict_count to 0.
REQ-029 SHALL abandon a CLEAR sweep immediately on reset and restart in RUN after rst_n deasserts.

Verification
REQ-030 SHALL cover: after reset, request pc=0x100 -> next cycle pred_resp_valid=1, pred_resp_taken=0.
REQ-031 SHALL cover: three res_valid updates with pc=0x100, res_taken=1, then request 0x100 -> taken=1; further updates leave counter at 11; four not-taken updates -> counter 00, prediction 0.
REQ-032 SHALL cover: same-edge request and taken update to 0x104 from state 01 -> response taken=0; next request -> taken=1.
REQ-033 SHALL cover: res_taken=1, res_pred_taken=0 -> mispredict pulses one cycle, count 0->1; count preloaded near 16'hFFFF via 0xFFFF events stays at 16'hFFFF.
REQ-034 SHALL cover: flush after training entries -> pred_req_ready=0 for exactly 64 cycles, updates ignored, then all entries predict 0 (weak-NT); flush at cycle 30 of a sweep extends it to 64 cycles after the second flush.
REQ-035 SHALL cover: rst_n asserted mid-CLEAR between edges -> outputs 0 immediately, pred_req_ready=1, all entries 01.
